// File: rtl/mc_controller.sv
// Multicycle ARM control sequencer: walks each instruction through
// FETCH..writeback, decodes dp ops, holds NZCV and evaluates Cond.
//
// Ports:
//   clk, reset (async, active-low)
//   Cond/Op/Funct/Rd : latched instruction fields
//   ALUFlags         : {N,Z,C,V} from the ALU this cycle
//   PCWrite, MemWrite, RegWrite, IRWrite : datapath enables
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
//                    : datapath mux selects / ALU op
//   Flags            : architectural {N,Z,C,V}
//   State            : current sequencer state (debug)
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;
    logic       r_cond_ok;

    logic [3:0] w_cmd;
    logic [1:0] w_dp_ctl;
    logic       w_cmp;
    logic       w_cv_upd;
    logic       w_wr_ok;
    logic       w_s_bit;
    logic       w_cond_pass;
    logic       w_in_exec;
    logic       w_flag_upd;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_rd_pc;

    assign w_cmd   = Funct[4:1];
    assign w_n     = r_flags[3];
    assign w_z     = r_flags[2];
    assign w_c     = r_flags[1];
    assign w_v     = r_flags[0];
    assign w_rd_pc = (Rd == 4'd15);

    // Data-processing decode. Unknown commands run as ADD but never
    // write the register file.
    always_comb begin
        w_dp_ctl = 2'b00;
        w_cmp    = 1'b0;
        w_cv_upd = 1'b0;
        w_wr_ok  = 1'b1;
        case (w_cmd)
            4'b0100: begin
                w_dp_ctl = 2'b00;
                w_cv_upd = 1'b1;
            end
            4'b0010: begin
                w_dp_ctl = 2'b01;
                w_cv_upd = 1'b1;
            end
            4'b0000: w_dp_ctl = 2'b10;
            4'b1100: w_dp_ctl = 2'b11;
            4'b1010: begin
                w_dp_ctl = 2'b01;
                w_cmp    = 1'b1;
                w_cv_upd = 1'b1;
                w_wr_ok  = 1'b0;
            end
            default: w_wr_ok = 1'b0;
        endcase
    end

    assign w_s_bit    = Funct[0] | w_cmp;
    assign w_in_exec  = (r_state == S_EXECUTER) ||
                        (r_state == S_EXECUTEI);
    assign w_flag_upd = w_in_exec & r_cond_ok & w_s_bit;

    always_comb begin
        w_cond_pass = 1'b0;
        case (Cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = ~w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = ~w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = ~w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = ~w_v;
            4'b1000: w_cond_pass = w_c & ~w_z;
            4'b1001: w_cond_pass = ~w_c | w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
            4'b1101: w_cond_pass = w_z | (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_flags   <= 4'b0000;
            r_cond_ok <= 1'b0;
        end else begin
            r_state <= w_next;
            // Latched once per instruction so its own flag update
            // cannot change its writeback.
            if (r_state == S_DECODE) begin
                r_cond_ok <= w_cond_pass;
            end
            if (w_flag_upd) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_cv_upd) begin
                    r_flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01: w_next = S_MEMADR;
                    2'b00: w_next = Funct[5] ? S_EXECUTEI
                                             : S_EXECUTER;
                    2'b10: w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (r_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = r_cond_ok;
                PCWrite   = r_cond_ok & w_rd_pc;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = r_cond_ok;
            end
            S_EXECUTER: ALUControl = w_dp_ctl;
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_dp_ctl;
            end
            S_ALUWB: begin
                RegWrite = r_cond_ok & w_wr_ok;
                PCWrite  = r_cond_ok & w_wr_ok & w_rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = r_cond_ok;
            end
            default: ;
        endcase
    end

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
    assign Flags  = r_flags;
    assign State  = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction behavioural model plus
// literal spot checks on key outputs.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Cond = '0;
    logic [1:0] Op = '0;
    logic [5:0] Funct = '0;
    logic [3:0] Rd = '0;
    logic [3:0] ALUFlags = '0;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [1:0] ALUControl;
    logic [3:0] Flags, State;

    mc_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op),
        .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Flags(Flags), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, mw, rw, irw, adr;
        logic [1:0] rs, sa, sb, res, imm, alu;
        logic [3:0] fl;
    } vec_t;

    vec_t got, expv, last_got;
    logic exp_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mw_cnt = 0;
    logic [3:0] m_flags = 4'b0000;

    assign got = '{State, PCWrite, MemWrite, RegWrite, IRWrite,
                   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc,
                   ImmSrc, ALUControl, Flags};

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            last_got = got;
            if (got.mw) mw_cnt++;
            if (got !== expv) begin
                errors++;
                $display("FAIL cycle_vec t=%0t got=%h want=%h",
                         $time, got, expv);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] a,
                       input logic [3:0] w);
        checks++;
        if (a !== w) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, a, w);
        end
    endtask

    function automatic logic cond_pass(input logic [3:0] c,
                                       input logic [3:0] f);
        logic n, z, cc, v;
        {n, z, cc, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cc;
            4'h3: return !cc;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cc && !z;
            4'h9: return !cc || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] dp_alu(input logic [3:0] cmd);
        if (cmd == 4'b0010 || cmd == 4'b1010) return 2'b01;
        if (cmd == 4'b0000) return 2'b10;
        if (cmd == 4'b1100) return 2'b11;
        return 2'b00;
    endfunction

    // Expected outputs for one cycle of the instruction in state st.
    function automatic vec_t model(input int st,
                                   input logic [31:0] ins,
                                   input logic ok,
                                   input logic [3:0] fl);
        vec_t v;
        logic [1:0] op;
        logic [3:0] cmd;
        logic wr;
        op  = ins[27:26];
        cmd = ins[24:21];
        v = '0;
        v.st  = st[3:0];
        v.imm = op;
        v.rs  = {op == 2'b01, op == 2'b10};
        v.fl  = fl;
        wr = (cmd == 4'b0100 || cmd == 4'b0010 ||
              cmd == 4'b0000 || cmd == 4'b1100);
        case (st)
            0: begin
                v.irw = 1; v.sa = 2'b01; v.sb = 2'b10;
                v.res = 2'b10; v.pcw = 1;
            end
            1: begin
                v.sa = 2'b01; v.sb = 2'b10; v.res = 2'b10;
            end
            2: v.sb = 2'b01;
            3: v.adr = 1;
            4: begin
                v.res = 2'b01; v.rw = ok;
                v.pcw = ok && ins[15:12] == 4'd15;
            end
            5: begin v.adr = 1; v.mw = ok; end
            6: v.alu = dp_alu(cmd);
            7: begin v.sb = 2'b01; v.alu = dp_alu(cmd); end
            8: begin
                v.rw  = ok && wr;
                v.pcw = ok && wr && ins[15:12] == 4'd15;
            end
            9: begin
                v.sb = 2'b01; v.res = 2'b10; v.pcw = ok;
            end
            default: ;
        endcase
        return v;
    endfunction

    // Runs one instruction; stops after ncyc cycles if ncyc > 0.
    task automatic run(input logic [31:0] ins,
                       input logic [3:0] af, input int ncyc = 0);
        int q[$];
        logic ok;
        logic [3:0] nf;
        logic [3:0] cmd;
        int n;
        Cond  = ins[31:28];
        Op    = ins[27:26];
        Funct = ins[25:20];
        Rd    = ins[15:12];
        ALUFlags = af;
        cmd = ins[24:21];
        ok  = cond_pass(ins[31:28], m_flags);
        q = '{0, 1};
        case (ins[27:26])
            2'b01: begin
                q.push_back(2);
                if (ins[20]) begin q.push_back(3); q.push_back(4); end
                else q.push_back(5);
            end
            2'b00: begin
                q.push_back(ins[25] ? 7 : 6);
                q.push_back(8);
            end
            2'b10: q.push_back(9);
            default: ;
        endcase
        nf = m_flags;
        if (ins[27:26] == 2'b00 && ok &&
            (ins[20] || cmd == 4'b1010)) begin
            nf[3:2] = af[3:2];
            if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)
                nf[1:0] = af[1:0];
        end
        n = (ncyc > 0) ? ncyc : q.size();
        mw_cnt = 0;
        for (int i = 0; i < n; i++) begin
            expv = model(q[i], ins, ok, (q[i] == 8) ? nf : m_flags);
            exp_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        exp_valid = 1'b0;
        if (ncyc == 0) m_flags = nf;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_state", State, 4'd0);
        chk("rst_irw", {3'b0, IRWrite}, 4'd1);
        chk("rst_pcw", {3'b0, PCWrite}, 4'd1);
        chk("rst_flags", Flags, 4'b0000);
        @(posedge clk); #1;
        // sync back to FETCH: restart from reset
        reset = 1'b0; #1;
        @(posedge clk); #1 reset = 1'b1;

        run(32'hE0802001, 4'b1111);
        chk("add_wb_rw", {3'b0, last_got.rw}, 4'd1);
        chk("add_flags", Flags, 4'b0000);
        run(32'hE5902004, 4'b0000);
        chk("ldr_wb_res", {2'b0, last_got.res}, 4'd1);
        run(32'hE5802004, 4'b0000);
        chk("str_mw_cnt", mw_cnt[3:0], 4'd1);
        run(32'hE3520005, 4'b0100);
        chk("cmp_flags", Flags, 4'b0100);
        chk("cmp_rw", {3'b0, last_got.rw}, 4'd0);
        run(32'h0A000002, 4'b0000);
        chk("beq_taken", {3'b0, last_got.pcw}, 4'd1);
        run(32'hE3520005, 4'b0000);
        chk("cmp0_flags", Flags, 4'b0000);
        run(32'h0A000002, 4'b0000);
        chk("beq_not", {3'b0, last_got.pcw}, 4'd0);
        run(32'hE3520005, 4'b0100);
        run(32'h10802001, 4'b0000);
        chk("addne_rw", {3'b0, last_got.rw}, 4'd0);
        run(32'hE080F001, 4'b0000);
        chk("pc_dst_pcw", {3'b0, last_got.pcw}, 4'd1);
        chk("pc_dst_rw", {3'b0, last_got.rw}, 4'd1);
        run(32'hEC000000, 4'b0000);
        run(32'hE3520005, 4'b0011);
        run(32'hE0112003, 4'b1000);
        chk("ands_flags", Flags, 4'b1011);
        run(32'h05802004, 4'b0000);
        chk("streq_mw", mw_cnt[3:0], 4'd0);

        run(32'hE5902004, 4'b0000, 3);
        chk("pre_rst_memrd", State, 4'd3);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_state", State, 4'd0);
        chk("mid_rst_irw", {3'b0, IRWrite}, 4'd1);
        chk("mid_rst_pcw", {3'b0, PCWrite}, 4'd1);
        chk("mid_rst_rw", {3'b0, RegWrite}, 4'd0);
        chk("mid_rst_adr", {3'b0, AdrSrc}, 4'd0);
        chk("mid_rst_flags", Flags, 4'b0000);
        @(posedge clk); #1 reset = 1'b1;
        m_flags = 4'b0000;
        run(32'hE0802001, 4'b0000);
        run(32'hE5902004, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
